// File: rtl/unary_mul_seq.sv
// unary_mul_seq: sequencer that drives a unary (stochastic) border multiplier and counts its output ones
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid / in_ready      operand handshake (in_ready only in IDLE)
//   in_data_i, in_data_w     unsigned operands, WIDTH-1 bits each
//   mul_data_i, mul_data_w   latched operands driven to the multiplier
//   mul_rst_n                active-low clear of the multiplier Sobol generators (high only in RUN/DONE)
//   mul_bit                  multiplier output bitstream, sampled only in RUN
//   out_valid / out_ready    result handshake
//   out_acc                  scaled count of mul_bit ones
//   busy                     high in every state except IDLE
//   in_len_log2              log2 of the stream length, present only with UNARY_EARLY_TERM_EN defined
//
// Build option: define UNARY_EARLY_TERM_EN to allow stream lengths 2^in_len_log2 shorter than 2^(WIDTH-1).
module unary_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-2:0] in_data_i,
    input  logic [WIDTH-2:0] in_data_w,
    output logic [WIDTH-2:0] mul_data_i,
    output logic [WIDTH-2:0] mul_data_w,
    output logic             mul_rst_n,
    input  logic             mul_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             busy
`ifdef UNARY_EARLY_TERM_EN
    ,
    input  logic [$clog2(WIDTH)-1:0] in_len_log2
`endif
);
    localparam int LW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cyc;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt_nx;
    logic [LW-1:0]    len_lg;
    logic [LW-1:0]    shift;
    logic             last;
`ifdef UNARY_EARLY_TERM_EN
    // length is clamped to the nominal maximum so the count can never wrap
    always_ff @(posedge clk) begin
        if (rst)
            len_lg <= '0;
        else if (state == IDLE && in_valid)
            len_lg <= (in_len_log2 > LW'(WIDTH - 1)) ? LW'(WIDTH - 1) : in_len_log2;
    end
    assign shift = LW'(WIDTH - 1) - len_lg;
`else
    assign len_lg = LW'(WIDTH - 1);
    assign shift  = '0;
`endif
    assign cnt_nx = cnt + WIDTH'(mul_bit);
    assign last   = cyc == ((WIDTH'(1) << len_lg) - WIDTH'(1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mul_data_i <= '0;
            mul_data_w <= '0;
            cnt        <= '0;
            cyc        <= '0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mul_data_i <= in_data_i;
                    mul_data_w <= in_data_w;
                    state      <= CLR;
                end
                CLR: begin
                    cnt   <= '0;
                    cyc   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt_nx;
                    cyc <= cyc + WIDTH'(1);
                    if (last) begin
                        acc   <= cnt_nx << shift;
                        state <= DONE;
                    end
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
    // outputs decode the state register and are forced inactive while rst is high
    assign in_ready  = !rst && state == IDLE;
    assign busy      = !rst && state != IDLE;
    assign out_valid = !rst && state == DONE;
    assign mul_rst_n = !rst && (state == RUN || state == DONE);
    assign out_acc   = rst ? '0 : acc;
endmodule

// File: doc/unary_mul_seq.md
UNARY_MUL_SEQ -- requirements
Module: unary_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which is the operand/accumulator width; operands are WIDTH-1 bits and the nominal stream length is L_MAX = 2^(WIDTH-1).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, which presents an operand pair.
REQ-005 SHALL have port in_ready, output, 1, which indicates the block accepts operands.
REQ-006 SHALL have ports in_data_i and in_data_w, input, WIDTH-1 each, the unsigned operands.
REQ-007 SHALL have ports mul_data_i and mul_data_w, output, WIDTH-1 each, the registered operands driven to the border multiplier.
REQ-008 SHALL have port mul_rst_n, output, 1, an active-low clear to both multiplier Sobol generators.
REQ-009 SHALL have port mul_bit, input, 1, the multiplier output bitstream.
REQ-010 SHALL have port out_valid, output, 1, which indicates the result is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer's acceptance of the result.
REQ-012 SHALL have port out_acc, output, WIDTH, the scaled count of mul_bit ones.
REQ-013 SHALL have port busy, output, 1, which is high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, CLR, RUN and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an in_valid&in_ready cycle latches both operands into mul_data_i/w and moves to CLR.
REQ-016 SHALL, in CLR (exactly one cycle), drive mul_rst_n=0, clear the accumulator and cycle counter, and then enter RUN.
REQ-017 SHALL, in RUN, drive mul_rst_n=1 and add mul_bit to a WIDTH-bit count each cycle for exactly L cycles (L=L_MAX unless REQ-026 applies).
REQ-018 SHALL, after the L-th RUN cycle, enter DONE with out_valid=1 and out_acc = count << (WIDTH-1-log2 L).
REQ-019 SHALL, in DONE, hold out_valid, out_acc and mul_data_i/w stable until out_ready=1; that cycle returns the block to IDLE.
REQ-020 SHALL give a latency from the acceptance edge to out_valid high of L+1 cycles (1 CLR + L RUN).
REQ-021 SHALL ignore in_valid while busy, since in_ready=0; back-to-back operations have a minimum one-cycle IDLE gap.
REQ-022 SHALL ensure the count never wraps: its maximum is L ≤ 2^(WIDTH-1) < 2^WIDTH; out_acc=2^(WIDTH-1) is legal.
REQ-023 SHALL leave mul_bit unsampled outside RUN.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, from any state including mid-RUN, force IDLE; clear the count, the cycle counter and mul_data_i/w to 0; and drive out_valid=0, out_acc=0, busy=0 and in_ready=0 while rst is high.
REQ-025 SHALL drive mul_rst_n=0 while rst=1 and in IDLE; it is high only in RUN and DONE.

Configuration
REQ-026 SHALL, when macro UNARY_EARLY_TERM_EN is defined, add port in_len_log2 (input, clog2(WIDTH) bits), latched with the operands, and set L = 2^min(in_len_log2, WIDTH-1).
REQ-027 SHALL, when UNARY_EARLY_TERM_EN is undefined, omit in_len_log2, fix L=L_MAX, and apply a shift of 0.

Verification
REQ-028 SHALL be verified for nominal length: WIDTH=8, accept operands, mul_bit tied 1 -> mul_rst_n low exactly 1 cycle, out_valid 129 cycles after acceptance, out_acc=128.
REQ-029 SHALL be verified for the zero stream: mul_bit tied 0 -> out_acc=0, out_valid after 129 cycles; with mul_bit alternating 1/0 -> out_acc=64.
REQ-030 SHALL be verified for handshake and stall: out_ready held 0 for 10 cycles in DONE -> out_acc/out_valid stable, in_valid pulses ignored, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-031 SHALL be verified for reset mid-RUN: rst=1 at RUN cycle 50 -> next cycle IDLE, out_acc=0, busy=0, mul_rst_n=0; a new operation then completes normally.
REQ-032 SHALL be verified with UNARY_EARLY_TERM_EN defined: in_len_log2=4, mul_bit tied 1 -> 16 RUN cycles, out_valid 17 cycles after acceptance, out_acc=16<<3=128; in_len_log2=7 behaves as nominal.
REQ-033 SHALL be verified in the integrated case: with the border multiplier attached, in_data_i=64 and in_data_w=127 -> out_acc=64; in_data_i=0 -> out_acc=0.
